// File: rtl/ibex_data_router.sv
// ============================================================================
// Module   : ibex_data_router
// Brief    : Routes Ibex data-port requests to NumTgt targets by base/mask
//            decode and returns responses to the core in grant order.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ibex_data_router #(
    parameter int unsigned          NumTgt      = 4,
    parameter int unsigned          MaxOut      = 16,
    parameter int unsigned          RspDepth    = 16,
    parameter logic [NumTgt*32-1:0] TgtBase     = '0,
    parameter logic [NumTgt*32-1:0] TgtMask     = '0,
    parameter logic [NumTgt-1:0]    TgtRo       = '0,
    parameter int unsigned          DefTgt      = NumTgt - 1,
    parameter bit                   UnmappedErr = 1'b0
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          data_req_i,
    output logic                          data_gnt_o,
    input  logic                          data_we_i,
    input  logic [3:0]                    data_be_i,
    input  logic [31:0]                   data_addr_i,
    output logic                          data_rvalid_o,
    output logic [31:0]                   data_rdata_o,
    output logic                          data_err_o,
    output logic [NumTgt-1:0]             tgt_req_o,
    input  logic [NumTgt-1:0]             tgt_gnt_i,
    output logic [31:0]                   tgt_addr_o,
    output logic                          tgt_we_o,
    output logic [3:0]                    tgt_be_o,
    input  logic [NumTgt-1:0]             tgt_rvalid_i,
    input  logic [32*NumTgt-1:0]          tgt_rdata_i,
    input  logic [NumTgt-1:0]             tgt_err_i,
    output logic [$clog2(MaxOut+1)-1:0]   outstanding_o,
    output logic                          rsp_overflow_o
);

    localparam int unsigned TW  = (NumTgt > 1) ? $clog2(NumTgt) : 1;
    localparam int unsigned QAW = $clog2(MaxOut);
    localparam int unsigned CW  = $clog2(MaxOut + 1);
    localparam int unsigned FAW = $clog2(RspDepth);
    localparam int unsigned FCW = $clog2(RspDepth + 1);

    // Outstanding queue: entry = {is_local_error, target index}
    logic [TW:0]     q_mem_q [MaxOut];
    logic [QAW-1:0]  q_wptr_q, q_rptr_q;
    logic [CW-1:0]   q_cnt_q;
    logic            rsp_overflow_q;

    logic [TW-1:0]   sel;
    logic            mapped, is_le, q_full, q_push, q_pop;
    logic [TW:0]     head;
    logic [NumTgt-1:0] f_empty, f_pop, f_ovf, routed_pending;
    logic [32:0]     f_head [NumTgt];
    logic [QAW-1:0]  scan_idx;

    assign tgt_addr_o     = data_addr_i;
    assign tgt_we_o       = data_we_i;
    assign tgt_be_o       = data_be_i;
    assign outstanding_o  = q_cnt_q;
    assign rsp_overflow_o = rsp_overflow_q;
    assign head           = q_mem_q[q_rptr_q];

    // Address decode; descending scan so the lowest matching region wins
    always_comb begin
        sel    = TW'(DefTgt);
        mapped = 1'b0;
        for (int i = NumTgt - 1; i >= 0; i--) begin
            if ((data_addr_i & ~TgtMask[i*32 +: 32]) == TgtBase[i*32 +: 32]) begin
                sel    = TW'(i);
                mapped = 1'b1;
            end
        end
        is_le = (~mapped & UnmappedErr) | (data_we_i & TgtRo[sel]);
    end

    // Response sequencing from the queue head; pop does not depend on the grant
    always_comb begin
        data_rvalid_o = 1'b0;
        data_rdata_o  = '0;
        data_err_o    = 1'b0;
        q_pop         = 1'b0;
        f_pop         = '0;
        if (q_cnt_q != '0) begin
            if (head[TW]) begin
                data_rvalid_o = 1'b1;
                data_err_o    = 1'b1;
                q_pop         = 1'b1;
            end else if (!f_empty[head[TW-1:0]]) begin
                data_rvalid_o = 1'b1;
                {data_rdata_o, data_err_o} = f_head[head[TW-1:0]];
                q_pop         = 1'b1;
                f_pop[head[TW-1:0]] = 1'b1;
            end
        end
    end

    // Grant and one-hot target request; a full queue blocks both
    always_comb begin
        q_full     = (q_cnt_q == CW'(MaxOut)) & ~q_pop;
        data_gnt_o = data_req_i & ~q_full & (is_le | tgt_gnt_i[sel]);
        q_push     = data_gnt_o;
        tgt_req_o  = '0;
        for (int i = 0; i < NumTgt; i++) begin
            tgt_req_o[i] = data_req_i & ~is_le & ~q_full & (sel == TW'(i));
        end
    end

    // Queue storage (no reset needed: validity is tracked by the count)
    always_ff @(posedge clk_i) begin
        if (q_push) begin
            q_mem_q[q_wptr_q] <= {is_le, sel};
        end
    end

    // Queue pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_wptr_q       <= '0;
            q_rptr_q       <= '0;
            q_cnt_q        <= '0;
            rsp_overflow_q <= 1'b0;
        end else begin
            if (q_push) q_wptr_q <= q_wptr_q + 1'b1;
            if (q_pop)  q_rptr_q <= q_rptr_q + 1'b1;
            q_cnt_q <= q_cnt_q + CW'(q_push) - CW'(q_pop);
            if (|f_ovf) rsp_overflow_q <= 1'b1;
        end
    end

    for (genvar g = 0; g < NumTgt; g++) begin : g_rsp_fifo
        logic [32:0]    mem_q [RspDepth];
        logic [FAW-1:0] wptr_q, rptr_q;
        logic [FCW-1:0] cnt_q;
        logic           full, push;

        assign full       = (cnt_q == FCW'(RspDepth));
        assign push       = tgt_rvalid_i[g] & ~full;
        assign f_ovf[g]   = tgt_rvalid_i[g] & full;
        assign f_empty[g] = (cnt_q == '0);
        assign f_head[g]  = mem_q[rptr_q];

        // Response storage {rdata, err}
        always_ff @(posedge clk_i) begin
            if (push) mem_q[wptr_q] <= {tgt_rdata_i[32*g +: 32], tgt_err_i[g]};
        end

        // FIFO pointers and occupancy
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
            end else begin
                if (push)     wptr_q <= wptr_q + 1'b1;
                if (f_pop[g]) rptr_q <= rptr_q + 1'b1;
                cnt_q <= cnt_q + FCW'(push) - FCW'(f_pop[g]);
            end
        end
    end

    // Targets that currently own a ROUTED queue entry (including this cycle's push)
    always_comb begin
        routed_pending = '0;
        scan_idx       = '0;
        for (int k = 0; k < MaxOut; k++) begin
            scan_idx = q_rptr_q + QAW'(k);
            if ((CW'(k) < q_cnt_q) && !q_mem_q[scan_idx][TW]) begin
                routed_pending[q_mem_q[scan_idx][TW-1:0]] = 1'b1;
            end
        end
        if (q_push && !is_le) routed_pending[sel] = 1'b1;
    end

    a_req_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(tgt_req_o));

    a_rvalid_expected: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (tgt_rvalid_i & ~routed_pending) == '0);

endmodule

`default_nettype wire

// File: tb/tb_ibex_data_router.sv
// ============================================================================
// Module   : tb_ibex_data_router
// Brief    : Directed and randomized self-checking bench for ibex_data_router
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ibex_data_router;

    localparam logic [127:0] BASE = {32'h4000_0000, 32'h3000_0000, 32'h2000_0000, 32'h1000_0000};
    localparam logic [127:0] MASK = {4{32'h0000_FFFF}};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req = 1'b0, req2 = 1'b0, we = 1'b0;
    logic [3:0]   be = 4'hF;
    logic [31:0]  addr = '0;
    logic [3:0]   tgt_gnt = '0, tgt_rvalid = '0, tgt_err = '0;
    logic [127:0] tgt_rdata = '0;

    logic         gnt, rvalid, err, ovf;
    logic [31:0]  rdata, taddr;
    logic [3:0]   treq, tbe;
    logic         twe;
    logic [2:0]   outst;

    logic         gnt2, rvalid2, err2, ovf2, twe2;
    logic [31:0]  rdata2, taddr2;
    logic [3:0]   treq2, tbe2;
    logic [2:0]   outst2;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state for the randomized phase
    bit          gq_le [$];
    int          gq_t  [$];
    logic [32:0] sent_q [4][$];
    int          acc [4];

    always #5 clk = ~clk;

    ibex_data_router #(
        .NumTgt(4), .MaxOut(4), .RspDepth(2), .TgtBase(BASE), .TgtMask(MASK),
        .TgtRo(4'b0010), .DefTgt(3), .UnmappedErr(1'b1)
    ) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .data_req_i(req), .data_gnt_o(gnt),
        .data_we_i(we), .data_be_i(be), .data_addr_i(addr),
        .data_rvalid_o(rvalid), .data_rdata_o(rdata), .data_err_o(err),
        .tgt_req_o(treq), .tgt_gnt_i(tgt_gnt), .tgt_addr_o(taddr), .tgt_we_o(twe),
        .tgt_be_o(tbe), .tgt_rvalid_i(tgt_rvalid), .tgt_rdata_i(tgt_rdata),
        .tgt_err_i(tgt_err), .outstanding_o(outst), .rsp_overflow_o(ovf)
    );

    // Same map, unmapped addresses fall through to the default target
    ibex_data_router #(
        .NumTgt(4), .MaxOut(4), .RspDepth(2), .TgtBase(BASE), .TgtMask(MASK),
        .TgtRo(4'b0010), .DefTgt(3), .UnmappedErr(1'b0)
    ) u_dut_def (
        .clk_i(clk), .rst_ni(rst_n), .data_req_i(req2), .data_gnt_o(gnt2),
        .data_we_i(we), .data_be_i(be), .data_addr_i(addr),
        .data_rvalid_o(rvalid2), .data_rdata_o(rdata2), .data_err_o(err2),
        .tgt_req_o(treq2), .tgt_gnt_i(4'b0000), .tgt_addr_o(taddr2), .tgt_we_o(twe2),
        .tgt_be_o(tbe2), .tgt_rvalid_i(4'b0000), .tgt_rdata_i(128'b0),
        .tgt_err_i(4'b0000), .outstanding_o(outst2), .rsp_overflow_o(ovf2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        req = 1'b0; req2 = 1'b0; we = 1'b0; tgt_gnt = '0; tgt_rvalid = '0; tgt_err = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Region map from the address alone: regions k=1..4 sit at k<<28, 64 KiB each
    task automatic decode(input logic [31:0] a, output int t, output bit hit);
        int k;
        k   = int'(a >> 28);
        hit = (a[27:16] == 12'h000) && (k >= 1) && (k <= 4);
        t   = hit ? k - 1 : 3;
    endtask

    // One randomized cycle: drive, predict, compare, then advance the model
    task automatic rand_cycle(input bit allow_req);
        int t, sel;
        bit hit, le, exp_rv, exp_full, exp_gnt;
        logic [32:0] exp_rsp;
        logic [3:0]  exp_treq;
        @(negedge clk);
        req = allow_req && ($urandom_range(0, 3) != 0);
        t   = $urandom_range(0, 4);
        addr = (t < 4) ? ((32'(t + 1) << 28) | {16'h0, 16'($urandom_range(0, 16'hFFFF))})
                       : (32'h5000_0000 | 32'($urandom_range(0, 32'h00FF_FFFF)));
        we      = 1'($urandom_range(0, 1));
        be      = 4'($urandom_range(0, 15));
        tgt_gnt = 4'($urandom_range(0, 15));
        for (int i = 0; i < 4; i++) begin
            tgt_rvalid[i] = (acc[i] > 0) && (sent_q[i].size() < 2) && ($urandom_range(0, 1) == 1);
            tgt_rdata[32*i +: 32] = $urandom;
            tgt_err[i] = ($urandom_range(0, 7) == 0);
        end
        #1;
        exp_rv  = (gq_le.size() > 0) && (gq_le[0] || (sent_q[gq_t[0]].size() > 0));
        exp_rsp = '0;
        if (exp_rv) exp_rsp = gq_le[0] ? 33'h1 : sent_q[gq_t[0]][0];
        chk("rnd_rvalid", rvalid, exp_rv);
        chk("rnd_rsp", {rdata, err}, exp_rsp);
        chk("rnd_outstanding", outst, gq_le.size());
        decode(addr, sel, hit);
        le       = !hit || (we && sel == 1);
        exp_full = (gq_le.size() == 4) && !exp_rv;
        exp_gnt  = req && !exp_full && (le || tgt_gnt[sel]);
        exp_treq = (req && !le && !exp_full) ? (4'b0001 << sel) : 4'b0000;
        chk("rnd_gnt", gnt, exp_gnt);
        chk("rnd_tgt_req", treq, exp_treq);
        chk("rnd_passthru", {taddr, twe, tbe}, {addr, we, be});
        if (exp_rv) begin
            if (!gq_le[0]) void'(sent_q[gq_t[0]].pop_front());
            void'(gq_le.pop_front());
            void'(gq_t.pop_front());
        end
        for (int i = 0; i < 4; i++) begin
            if (tgt_rvalid[i]) begin
                sent_q[i].push_back({tgt_rdata[32*i +: 32], tgt_err[i]});
                acc[i]--;
            end
        end
        if (exp_gnt) begin
            gq_le.push_back(le);
            gq_t.push_back(sel);
            if (!le) acc[sel]++;
        end
    endtask

    initial begin
        // ---- reset state
        do_reset();
        #1;
        chk("rst_outstanding", outst, 0);
        chk("rst_overflow", ovf, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_gnt", gnt, 0);

        // ---- basic read to T0, response one cycle after target rvalid
        @(negedge clk); req = 1; addr = 32'h1000_0010; tgt_gnt = 4'b0001;
        #1; chk("t0_treq", treq, 4'b0001); chk("t0_gnt", gnt, 1);
        @(negedge clk); idle(); tgt_rvalid = 4'b0001; tgt_rdata[31:0] = 32'hDEAD_BEEF;
        #1; chk("t0_out1", outst, 1); chk("t0_not_yet", rvalid, 0);
        @(negedge clk); idle();
        #1; chk("t0_rvalid", rvalid, 1); chk("t0_rsp", {rdata, err}, {32'hDEAD_BEEF, 1'b0});
        @(negedge clk);
        #1; chk("t0_out0", outst, 0);

        // ---- reorder: T1 then T0, T0 answers first
        @(negedge clk); req = 1; addr = 32'h2000_0000; tgt_gnt = 4'b0010;
        #1; chk("ro_gnt_t1", gnt, 1);
        @(negedge clk); addr = 32'h1000_0000; tgt_gnt = 4'b0001;
        #1; chk("ro_gnt_t0", gnt, 1);
        @(negedge clk); idle(); tgt_rvalid = 4'b0001; tgt_rdata[31:0] = 32'hAAAA_0000;
        #1; chk("ro_wait0", rvalid, 0);
        @(negedge clk); idle(); tgt_rvalid = 4'b0010; tgt_rdata[63:32] = 32'hBBBB_0000;
        #1; chk("ro_wait1", rvalid, 0);
        @(negedge clk); idle();
        #1; chk("ro_first", {rvalid, rdata}, {1'b1, 32'hBBBB_0000});
        @(negedge clk);
        #1; chk("ro_second", {rvalid, rdata}, {1'b1, 32'hAAAA_0000});
        @(negedge clk);
        #1; chk("ro_done", rvalid, 0);

        // ---- write to protected region, then a read of the same address
        @(negedge clk); req = 1; we = 1; addr = 32'h2000_0004; tgt_gnt = 4'b1111;
        #1; chk("wp_treq", treq, 4'b0000); chk("wp_gnt", gnt, 1);
        @(negedge clk); idle();
        #1; chk("wp_rsp", {rvalid, err, rdata}, {2'b11, 32'h0});
        @(negedge clk); req = 1; we = 0; addr = 32'h2000_0004; tgt_gnt = 4'b0010;
        #1; chk("wp_rd_treq", treq, 4'b0010);
        @(negedge clk); idle(); tgt_rvalid = 4'b0010; tgt_rdata[63:32] = 32'h1234_5678;
        @(negedge clk); idle();
        #1; chk("wp_rd_rsp", {rvalid, rdata, err}, {1'b1, 32'h1234_5678, 1'b0});

        // ---- target rvalid in the grant cycle
        @(negedge clk); req = 1; addr = 32'h3000_0100; tgt_gnt = 4'b0100;
        tgt_rvalid = 4'b0100; tgt_rdata[95:64] = 32'hC0FF_EE00; tgt_err = 4'b0100;
        #1; chk("sc_gnt", gnt, 1);
        @(negedge clk); idle();
        #1; chk("sc_rsp", {rvalid, rdata, err}, {1'b1, 32'hC0FF_EE00, 1'b1});

        // ---- unmapped address: local error here, default target on the other instance
        @(negedge clk); req = 1; req2 = 1; addr = 32'h5000_0000; tgt_gnt = 4'b1111;
        #1; chk("um_treq", treq, 4'b0000); chk("um_gnt", gnt, 1);
        chk("um_def_treq", treq2, 4'b1000); chk("um_def_gnt", gnt2, 0);
        @(negedge clk); idle();
        #1; chk("um_rsp", {rvalid, err, rdata}, {2'b11, 32'h0});

        // ---- queue full: four held T0 reads, fifth blocked until one returns
        do_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); req = 1; addr = 32'h1000_0000 + 32'(4 * k); tgt_gnt = 4'b0001;
            #1; chk("qf_fill_gnt", gnt, 1);
        end
        @(negedge clk);
        #1; chk("qf_out4", outst, 4); chk("qf_blk_gnt", gnt, 0); chk("qf_blk_treq", treq, 0);
        @(negedge clk); tgt_rvalid = 4'b0001; tgt_rdata[31:0] = 32'h0000_0011;
        #1; chk("qf_still_blk", gnt, 0);
        @(negedge clk); tgt_rvalid = 4'b0000;
        #1; chk("qf_pop_rv", rvalid, 1); chk("qf_gnt", gnt, 1); chk("qf_treq", treq, 4'b0001);
        @(negedge clk); idle();
        #1; chk("qf_out_keep", outst, 4);

        // ---- response FIFO overflow while T1 blocks the head; async reset clears it
        do_reset();
        @(negedge clk); req = 1; addr = 32'h2000_0000; tgt_gnt = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); req = 1; addr = 32'h1000_0000; tgt_gnt = 4'b0001;
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); idle(); tgt_rvalid = 4'b0001; tgt_rdata[31:0] = 32'(k);
        end
        @(negedge clk); idle();
        #1; chk("of_set", ovf, 1); chk("of_head_wait", rvalid, 0); chk("of_out", outst, 4);
        repeat (3) @(negedge clk);
        #1; chk("of_sticky", ovf, 1);
        #1; rst_n = 1'b0;
        #1; chk("of_rst_clear", ovf, 0); chk("of_rst_out", outst, 0);
        @(negedge clk); rst_n = 1'b1;

        // ---- randomized traffic against the reference model
        for (int i = 0; i < 4; i++) acc[i] = 0;
        for (int c = 0; c < 400; c++) rand_cycle(1'b1);
        for (int c = 0; c < 200 && gq_le.size() > 0; c++) rand_cycle(1'b0);
        @(negedge clk); idle();
        #1; chk("drain_outstanding", outst, 0);
        chk("rnd_no_overflow", ovf, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
